// File: rtl/wb_vram_arbiter.sv
// Two-master Wishbone arbiter in front of a shared video RAM slave.
// Master 0 is the CPU and master 1 is the display fetch. A CPU starvation counter and a slave timeout are included.
module wb_vram_arbiter #(
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned CPU_MAX_WAIT = 16
) (
    input  logic        clk_100MHz,
    input  logic        rst,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,

    output logic [1:0]  gnt_o
);

    localparam int TMO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int WAIT_W = (CPU_MAX_WAIT < 2) ? 1 : $clog2(CPU_MAX_WAIT + 1);
    localparam logic [TMO_W-1:0]  TMO_LIMIT  = TMO_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(CPU_MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t             state_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [WAIT_W-1:0]  wait_q;

    logic req0;
    logic req1;
    logic gnt0;
    logic gnt1;
    logic tmo_hit;
    logic wait_sat;
    logic enter_gnt0;
    logic enter_gnt1;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;
    assign gnt0 = (state_q == ST_GNT0);
    assign gnt1 = (state_q == ST_GNT1);
    assign gnt_o = {gnt1, gnt0};

    // An ack arriving in the same cycle as the limit wins over the timeout.
    assign tmo_hit  = (gnt0 | gnt1) & (tmo_q == TMO_LIMIT) & ~s_ack_i;
    assign wait_sat = (wait_q == WAIT_LIMIT);

    assign enter_gnt0 = (state_q == ST_IDLE) & req0 & (~req1 | wait_sat);
    assign enter_gnt1 = (state_q == ST_IDLE) & req1 & ~enter_gnt0;

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = 4'h0;
        s_adr_o = 32'h0;
        s_dat_o = 32'h0;
        if (gnt0) begin
            s_cyc_o = m0_cyc_i & ~tmo_hit;
            s_stb_o = m0_stb_i & ~tmo_hit;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (gnt1) begin
            s_cyc_o = m1_cyc_i & ~tmo_hit;
            s_stb_o = m1_stb_i & ~tmo_hit;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = gnt0 & s_ack_i;
    assign m1_ack_o = gnt1 & s_ack_i;
    assign m0_err_o = gnt0 & tmo_hit;
    assign m1_err_o = gnt1 & tmo_hit;

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            wait_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tmo_q <= '0;
                    if (enter_gnt0) begin
                        state_q <= ST_GNT0;
                    end else if (enter_gnt1) begin
                        state_q <= ST_GNT1;
                    end
                end
                ST_GNT0: begin
                    if (!m0_cyc_i || tmo_hit) begin
                        state_q <= ST_IDLE;
                        tmo_q   <= '0;
                    end else if (s_ack_i) begin
                        tmo_q <= '0;
                    end else if (s_stb_o) begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_GNT1: begin
                    if (!m1_cyc_i || tmo_hit) begin
                        state_q <= ST_IDLE;
                        tmo_q   <= '0;
                    end else if (s_ack_i) begin
                        tmo_q <= '0;
                    end else if (s_stb_o) begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tmo_q   <= '0;
                end
            endcase

            // CPU starvation counter: counts pending CPU cycles spent outside its own tenure.
            if (enter_gnt0 || !req0) begin
                wait_q <= '0;
            end else if (!gnt0 && !wait_sat) begin
                wait_q <= wait_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_vram_arbiter.sv
// Directed bench for wb_vram_arbiter; expected master responses go through a scoreboard queue checked by a monitor.
module tb_wb_vram_arbiter;

    logic        clk_100MHz;
    logic        rst;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_ack_i;
    logic [1:0]  gnt_o;

    int total = 0;
    int bad   = 0;

    // flags = {m0_ack, m1_ack, m0_err, m1_err}
    typedef struct {
        logic [3:0]  flags;
        logic [31:0] dat;
    } exp_t;
    exp_t exp_q[$];

    wb_vram_arbiter dut (
        .clk_100MHz(clk_100MHz), .rst(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .gnt_o(gnt_o)
    );

    initial begin
        clk_100MHz = 1'b0;
        forever #5 clk_100MHz = ~clk_100MHz;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] flags, input logic [31:0] dat);
        exp_t e;
        e.flags = flags;
        e.dat   = dat;
        exp_q.push_back(e);
    endtask

    // Monitor: any ack/err seen by a master must match the head of the queue.
    always @(negedge clk_100MHz) begin
        logic [3:0]  f;
        logic [31:0] d;
        exp_t        e;
        if (!rst) begin
            f = {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o};
            d = m0_ack_o ? m0_dat_o : m1_dat_o;
            if (f != 4'b0000) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_resp got flags=%b exp none at %0t", f, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (f !== e.flags || ((f[3] | f[2]) && d !== e.dat)) begin
                        bad++;
                        $display("FAIL resp got flags=%b dat=%h exp flags=%b dat=%h at %0t",
                                 f, d, e.flags, e.dat, $time);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_sel_i = 4'hF;
        m0_adr_i = 32'h0; m0_dat_i = 32'h0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_sel_i = 4'hF;
        m1_adr_i = 32'h0; m1_dat_i = 32'h0;
        s_dat_i = 32'h0; s_ack_i = 1'b1;

        // Reset state with a request and a stray slave ack present
        #23;
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
        chk("rst_s_stb", 32'(s_stb_o), 32'h0);
        chk("rst_m0_ack", 32'(m0_ack_o), 32'h0);
        chk("rst_m0_err", 32'(m0_err_o), 32'h0);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
        @(posedge clk_100MHz);
        #1 rst = 1'b0;
        tick();

        // CPU-only read, slave acks on the second granted cycle
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0100;
        #1;
        chk("pre_edge_gnt", 32'(gnt_o), 32'h0);
        chk("pre_edge_s_cyc", 32'(s_cyc_o), 32'h0);
        tick();
        chk("m0_gnt", 32'(gnt_o), 32'h1);
        chk("m0_s_cyc", 32'(s_cyc_o), 32'h1);
        chk("m0_s_adr", s_adr_o, 32'h0000_0100);
        chk("m0_s_we", 32'(s_we_o), 32'h0);
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'hCAFE_0001;
        push(4'b1000, 32'hCAFE_0001);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        chk("m0_release_gnt", 32'(gnt_o), 32'h0);

        // Slave ack while idle must not reach a master
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_0000;
        #2;
        chk("idle_ack_m0", 32'(m0_ack_o), 32'h0);
        chk("idle_ack_m1", 32'(m1_ack_o), 32'h0);
        tick();
        s_ack_i = 1'b0;

        // Simultaneous requests: display wins, then CPU after one idle cycle
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0200;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_sel_i = 4'h3;
        m1_adr_i = 32'h0000_0300; m1_dat_i = 32'h1234_5678;
        tick();
        chk("both_gnt", 32'(gnt_o), 32'h2);
        chk("both_s_adr", s_adr_o, 32'h0000_0300);
        chk("both_s_dat", s_dat_o, 32'h1234_5678);
        chk("both_s_we", 32'(s_we_o), 32'h1);
        chk("both_s_sel", 32'(s_sel_o), 32'h3);
        s_ack_i = 1'b1; s_dat_i = 32'hBEEF_0002;
        push(4'b0100, 32'hBEEF_0002);
        tick();
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        tick();
        chk("gap_gnt", 32'(gnt_o), 32'h0);
        chk("gap_s_cyc", 32'(s_cyc_o), 32'h0);
        tick();
        chk("after_gap_gnt", 32'(gnt_o), 32'h1);
        chk("after_gap_s_adr", s_adr_o, 32'h0000_0200);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        chk("both_done_gnt", 32'(gnt_o), 32'h0);

        // CPU starvation: wait=15 still loses, wait=16 wins
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0400;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h0000_0500;
        tick();
        chk("starve_first_gnt", 32'(gnt_o), 32'h2);
        repeat (13) tick();
        m1_cyc_i = 1'b0;
        tick();
        chk("starve_idle1", 32'(gnt_o), 32'h0);
        m1_cyc_i = 1'b1;
        tick();
        chk("wait15_m1_wins", 32'(gnt_o), 32'h2);
        repeat (3) tick();
        m1_cyc_i = 1'b0;
        tick();
        chk("starve_idle2", 32'(gnt_o), 32'h0);
        m1_cyc_i = 1'b1;
        tick();
        chk("wait16_cpu_wins", 32'(gnt_o), 32'h1);
        chk("wait16_s_adr", s_adr_o, 32'h0000_0400);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        chk("starve_done_gnt", 32'(gnt_o), 32'h0);

        // Timeout on display master: err exactly at count 255
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h0000_0600;
        tick();
        chk("tmo_gnt", 32'(gnt_o), 32'h2);
        repeat (254) tick();
        chk("tmo_early_err", 32'(m1_err_o), 32'h0);
        chk("tmo_early_stb", 32'(s_stb_o), 32'h1);
        push(4'b0001, 32'h0);
        tick();
        chk("tmo_err", 32'(m1_err_o), 32'h1);
        chk("tmo_s_cyc", 32'(s_cyc_o), 32'h0);
        chk("tmo_s_stb", 32'(s_stb_o), 32'h0);
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        chk("tmo_idle", 32'(gnt_o), 32'h0);
        chk("tmo_err_once", 32'(m1_err_o), 32'h0);

        // Ack coinciding with timeout count: ack wins
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0700;
        tick();
        repeat (255) tick();
        s_ack_i = 1'b1; s_dat_i = 32'hA5A5_0003;
        push(4'b1000, 32'hA5A5_0003);
        #1;
        chk("race_err", 32'(m0_err_o), 32'h0);
        chk("race_ack", 32'(m0_ack_o), 32'h1);
        chk("race_s_cyc", 32'(s_cyc_o), 32'h1);
        tick();
        s_ack_i = 1'b0;
        #1;
        chk("race_still_gnt", 32'(gnt_o), 32'h1);
        chk("race_cleared_err", 32'(m0_err_o), 32'h0);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        chk("race_idle", 32'(gnt_o), 32'h0);

        // Asynchronous reset in the middle of a display tenure
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h0000_0800;
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_0900;
        #1;
        chk("pre_rst_stb", 32'(s_stb_o), 32'h1);
        #1;
        rst = 1'b1; s_ack_i = 1'b1;
        #1;
        chk("arst_gnt", 32'(gnt_o), 32'h0);
        chk("arst_s_cyc", 32'(s_cyc_o), 32'h0);
        chk("arst_s_stb", 32'(s_stb_o), 32'h0);
        chk("arst_m1_ack", 32'(m1_ack_o), 32'h0);
        chk("arst_m1_err", 32'(m1_err_o), 32'h0);
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
        @(posedge clk_100MHz);
        #1 rst = 1'b0;
        chk("post_rst_gnt", 32'(gnt_o), 32'h0);
        tick();
        chk("post_rst_m0_gnt", 32'(gnt_o), 32'h1);
        chk("post_rst_s_adr", s_adr_o, 32'h0000_0900);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
